// File: rtl/aes_bram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_bram_pkg
// Brief    : Shared types, constants and address check for the AES BRAM port
// Revision : 1.0 - initial release
// ============================================================================
package aes_bram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_WR_ISSUE = 3'd3,
        ST_DONE     = 3'd4,
        ST_RELEASE  = 3'd5
    } state_e;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [3:0]  BE_ALL     = 4'hF;
    localparam int unsigned LAT_CNT_W  = 2;

    // 33-bit compare so a window ending at the top of memory cannot wrap
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int unsigned depth);
        logic [32:0] lo;
        logic [32:0] hi;
        logic [32:0] a;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + (33'(depth) * 33'(WORD_BYTES));
        return (addr[1:0] == 2'b00) && (a >= lo) && (a < hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_bram_port_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_bram_port_ctrl_if
// Brief    : AES-FSM request side and native BRAM port of the port controller
// Revision : 1.0 - initial release
// ============================================================================
interface aes_bram_port_ctrl_if;

    logic        aes_start_read;
    logic        aes_start_write;
    logic [31:0] aes_bram_addr;
    logic [31:0] aes_bram_write_addr;
    logic [31:0] aes_bram_write_data;
    logic        bram_complete;
    logic [31:0] aes_bram_read_data;
    logic        bram_err;
    logic        ctrl_busy;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [31:0] bram_addr;
    logic [31:0] bram_wrdata;
    logic [31:0] bram_rddata;

    modport slave (
        input  aes_start_read, aes_start_write, aes_bram_addr,
               aes_bram_write_addr, aes_bram_write_data, bram_rddata,
        output bram_complete, aes_bram_read_data, bram_err, ctrl_busy,
               bram_en, bram_we, bram_addr, bram_wrdata
    );

    modport master (
        output aes_start_read, aes_start_write, aes_bram_addr,
               aes_bram_write_addr, aes_bram_write_data, bram_rddata,
        input  bram_complete, aes_bram_read_data, bram_err, ctrl_busy,
               bram_en, bram_we, bram_addr, bram_wrdata
    );

endinterface
`default_nettype wire

// File: rtl/aes_bram_lat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : aes_bram_lat_cnt
// Brief    : Read-latency down-counter; done while the count sits at zero
// Revision : 1.0 - initial release
// ============================================================================
module aes_bram_lat_cnt
    import aes_bram_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic load_i,
    output logic      done_o
);

    logic [LAT_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= LAT_CNT_W'(RD_LAT - 1);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/aes_bram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes_bram_port_ctrl
// Brief    : Single-word read/write sequencer between the AES FSM and a BRAM
// Revision : 1.0 - initial release
// ============================================================================
module aes_bram_port_ctrl
    import aes_bram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned RD_LAT      = 1
) (
    input  wire logic           aes_clk,
    input  wire logic           aes_rst,
    aes_bram_port_ctrl_if.slave bus
);

    state_e      state_q;
    logic        is_wr_q;
    logic        busy_q;
    logic        complete_q;
    logic        err_q;
    logic        en_q;
    logic [3:0]  we_q;
    logic [31:0] addr_q;
    logic [31:0] wrdata_q;
    logic [31:0] rdata_q;

    logic w_cnt_load;
    logic w_cnt_done;
    logic w_req_low;

    assign w_cnt_load = (state_q == ST_RD_ISSUE);
    assign w_req_low  = is_wr_q ? !bus.aes_start_write : !bus.aes_start_read;

    aes_bram_lat_cnt #(
        .RD_LAT (RD_LAT)
    ) u_lat_cnt (
        .clk    (aes_clk),
        .rst    (aes_rst),
        .load_i (w_cnt_load),
        .done_o (w_cnt_done)
    );

    always_ff @(posedge aes_clk) begin
        if (aes_rst) begin
            state_q    <= ST_IDLE;
            is_wr_q    <= 1'b0;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
            err_q      <= 1'b0;
            en_q       <= 1'b0;
            we_q       <= 4'h0;
            addr_q     <= '0;
            wrdata_q   <= '0;
            rdata_q    <= '0;
        end else begin
            // Strobes default low so each is a single-cycle pulse
            complete_q <= 1'b0;
            err_q      <= 1'b0;
            en_q       <= 1'b0;
            we_q       <= 4'h0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.aes_start_write) begin
                        is_wr_q <= 1'b1;
                        busy_q  <= 1'b1;
                        if (addr_in_range(bus.aes_bram_write_addr, BASE_ADDR, DEPTH_WORDS)) begin
                            en_q     <= 1'b1;
                            we_q     <= BE_ALL;
                            addr_q   <= bus.aes_bram_write_addr;
                            wrdata_q <= bus.aes_bram_write_data;
                            state_q  <= ST_WR_ISSUE;
                        end else begin
                            complete_q <= 1'b1;
                            err_q      <= 1'b1;
                            state_q    <= ST_DONE;
                        end
                    end else if (bus.aes_start_read) begin
                        is_wr_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (addr_in_range(bus.aes_bram_addr, BASE_ADDR, DEPTH_WORDS)) begin
                            en_q    <= 1'b1;
                            addr_q  <= bus.aes_bram_addr;
                            state_q <= ST_RD_ISSUE;
                        end else begin
                            complete_q <= 1'b1;
                            err_q      <= 1'b1;
                            state_q    <= ST_DONE;
                        end
                    end
                end
                ST_WR_ISSUE: begin
                    complete_q <= 1'b1;
                    state_q    <= ST_DONE;
                end
                ST_RD_ISSUE: begin
                    state_q <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (w_cnt_done) begin
                        rdata_q    <= bus.bram_rddata;
                        complete_q <= 1'b1;
                        state_q    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    // Level-held request must drop before another is accepted
                    if (w_req_low) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.bram_complete      = complete_q;
    assign bus.bram_err           = err_q;
    assign bus.ctrl_busy          = busy_q;
    assign bus.bram_en            = en_q;
    assign bus.bram_we            = we_q;
    assign bus.bram_addr          = addr_q;
    assign bus.bram_wrdata        = wrdata_q;
    assign bus.aes_bram_read_data = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_bram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_bram_port_ctrl
// Brief    : Directed bench for the port controller at RD_LAT=1 and RD_LAT=3
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_bram_port_ctrl;

    logic clk;
    logic rst1;
    logic rst3;
    int   checks;
    int   errors;

    aes_bram_port_ctrl_if if1 ();
    aes_bram_port_ctrl_if if3 ();

    aes_bram_port_ctrl #(.BASE_ADDR(32'h0), .DEPTH_WORDS(1024), .RD_LAT(1)) dut1 (
        .aes_clk (clk),
        .aes_rst (rst1),
        .bus     (if1.slave)
    );

    aes_bram_port_ctrl #(.BASE_ADDR(32'h0), .DEPTH_WORDS(1024), .RD_LAT(3)) dut3 (
        .aes_clk (clk),
        .aes_rst (rst3),
        .bus     (if3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM models: read-first, data valid RD_LAT cycles after the enable cycle
    logic [31:0] mem1 [0:1023];
    logic [31:0] mem3 [0:1023];
    logic [31:0] p1;
    logic [31:0] p3a, p3b, p3c;

    always @(posedge clk) begin
        if (rst1) begin
            mem1[4] <= 32'hDEAD_BEEF;
        end else if (if1.bram_en) begin
            if (if1.bram_we == 4'hF) mem1[if1.bram_addr[11:2]] <= if1.bram_wrdata;
            p1 <= mem1[if1.bram_addr[11:2]];
        end
    end

    always @(posedge clk) begin
        if (rst3) begin
            mem3[0] <= 32'h1234_5678;
        end else if (if3.bram_en) begin
            if (if3.bram_we == 4'hF) mem3[if3.bram_addr[11:2]] <= if3.bram_wrdata;
            p3a <= mem3[if3.bram_addr[11:2]];
        end
        p3b <= p3a;
        p3c <= p3b;
    end

    assign if1.bram_rddata = p1;
    assign if3.bram_rddata = p3c;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int          n_en;
        int          n_cmp;
        logic [3:0]  first_we;
        logic [31:0] bad_addr [2];

        checks = 0;
        errors = 0;
        bad_addr[0] = 32'h0000_1000;
        bad_addr[1] = 32'h0000_0006;

        rst1 = 1'b1;
        rst3 = 1'b1;
        if1.aes_start_read = 1'b0;  if1.aes_start_write = 1'b0;
        if1.aes_bram_addr = '0;     if1.aes_bram_write_addr = '0;  if1.aes_bram_write_data = '0;
        if3.aes_start_read = 1'b0;  if3.aes_start_write = 1'b0;
        if3.aes_bram_addr = '0;     if3.aes_bram_write_addr = '0;  if3.aes_bram_write_data = '0;

        // Reset state
        tick(); tick();
        chk1 ("rst_complete", if1.bram_complete, 1'b0);
        chk1 ("rst_err",      if1.bram_err,      1'b0);
        chk1 ("rst_busy",     if1.ctrl_busy,     1'b0);
        chk1 ("rst_en",       if1.bram_en,       1'b0);
        chk32("rst_we",       {28'h0, if1.bram_we}, 32'h0);
        chk32("rst_addr",     if1.bram_addr,     32'h0);
        chk32("rst_wrdata",   if1.bram_wrdata,   32'h0);
        chk32("rst_rdata",    if1.aes_bram_read_data, 32'h0);
        chk1 ("rst3_busy",    if3.ctrl_busy,     1'b0);
        rst1 = 1'b0;
        rst3 = 1'b0;
        tick();

        // Read 0x10, request held after completion
        if1.aes_bram_addr = 32'h10;
        if1.aes_start_read = 1'b1;
        tick();
        chk1 ("rd_en_c1",   if1.bram_en, 1'b1);
        chk32("rd_addr_c1", if1.bram_addr, 32'h10);
        chk32("rd_we_c1",   {28'h0, if1.bram_we}, 32'h0);
        chk1 ("rd_busy_c1", if1.ctrl_busy, 1'b1);
        tick();
        chk1 ("rd_en_c2",   if1.bram_en, 1'b0);
        chk1 ("rd_cmp_c2",  if1.bram_complete, 1'b0);
        tick();
        chk1 ("rd_cmp_c3",  if1.bram_complete, 1'b1);
        chk1 ("rd_err_c3",  if1.bram_err, 1'b0);
        chk32("rd_data_c3", if1.aes_bram_read_data, 32'hDEAD_BEEF);
        n_en = 0;
        n_cmp = 0;
        repeat (5) begin
            tick();
            n_en  += int'(if1.bram_en);
            n_cmp += int'(if1.bram_complete);
        end
        chk32("rd_hold_en",   n_en, 0);
        chk32("rd_hold_cmp",  n_cmp, 0);
        chk1 ("rd_hold_busy", if1.ctrl_busy, 1'b1);
        if1.aes_start_read = 1'b0;
        tick();
        chk1 ("rd_idle_busy", if1.ctrl_busy, 1'b0);

        // Write 0xCAFE0001 to 0x20, then read it back
        if1.aes_bram_write_addr = 32'h20;
        if1.aes_bram_write_data = 32'hCAFE_0001;
        if1.aes_start_write = 1'b1;
        tick();
        chk1 ("wr_en_c1",     if1.bram_en, 1'b1);
        chk32("wr_we_c1",     {28'h0, if1.bram_we}, 32'hF);
        chk32("wr_addr_c1",   if1.bram_addr, 32'h20);
        chk32("wr_wrdata_c1", if1.bram_wrdata, 32'hCAFE_0001);
        tick();
        chk1 ("wr_cmp_c2",    if1.bram_complete, 1'b1);
        chk1 ("wr_en_c2",     if1.bram_en, 1'b0);
        chk1 ("wr_err_c2",    if1.bram_err, 1'b0);
        if1.aes_start_write = 1'b0;
        tick(); tick();
        chk1 ("wr_idle_busy", if1.ctrl_busy, 1'b0);
        if1.aes_bram_addr = 32'h20;
        if1.aes_start_read = 1'b1;
        tick(); tick(); tick();
        chk1 ("rb_cmp_c3",  if1.bram_complete, 1'b1);
        chk32("rb_data_c3", if1.aes_bram_read_data, 32'hCAFE_0001);
        if1.aes_start_read = 1'b0;
        tick(); tick();

        // Simultaneous read 0x10 and write 0x24: write first
        if1.aes_bram_addr = 32'h10;
        if1.aes_bram_write_addr = 32'h24;
        if1.aes_bram_write_data = 32'h55AA_55AA;
        if1.aes_start_read = 1'b1;
        if1.aes_start_write = 1'b1;
        n_en = 0;
        n_cmp = 0;
        first_we = 4'h0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (if1.bram_en) begin
                n_en++;
                if (n_en == 1) first_we = if1.bram_we;
            end
            if (if1.bram_complete) begin
                n_cmp++;
                if (n_cmp == 1) if1.aes_start_write = 1'b0;
                if (n_cmp == 2) begin
                    if1.aes_start_read = 1'b0;
                    chk32("both_rd_data", if1.aes_bram_read_data, 32'hDEAD_BEEF);
                end
            end
        end
        chk32("both_en_count",  n_en, 2);
        chk32("both_cmp_count", n_cmp, 2);
        chk32("both_first_we",  {28'h0, first_we}, 32'hF);
        chk1 ("both_idle_busy", if1.ctrl_busy, 1'b0);

        // Illegal reads: out of range and misaligned
        for (int k = 0; k < 2; k++) begin
            if1.aes_bram_addr = bad_addr[k];
            if1.aes_start_read = 1'b1;
            tick();
            chk1 ("bad_cmp_c1",  if1.bram_complete, 1'b1);
            chk1 ("bad_err_c1",  if1.bram_err, 1'b1);
            chk1 ("bad_en_c1",   if1.bram_en, 1'b0);
            chk32("bad_data_c1", if1.aes_bram_read_data, 32'hDEAD_BEEF);
            if1.aes_start_read = 1'b0;
            tick();
            chk1 ("bad_cmp_c2",  if1.bram_complete, 1'b0);
            chk1 ("bad_err_c2",  if1.bram_err, 1'b0);
            chk1 ("bad_en_c2",   if1.bram_en, 1'b0);
            tick();
            chk1 ("bad_idle_busy", if1.ctrl_busy, 1'b0);
        end

        // Illegal write just past the end
        if1.aes_bram_write_addr = 32'h0000_1000;
        if1.aes_start_write = 1'b1;
        tick();
        chk1 ("badwr_cmp_c1", if1.bram_complete, 1'b1);
        chk1 ("badwr_err_c1", if1.bram_err, 1'b1);
        chk1 ("badwr_en_c1",  if1.bram_en, 1'b0);
        if1.aes_start_write = 1'b0;
        tick(); tick();

        // Last legal word
        if1.aes_bram_addr = 32'h0000_0FFC;
        if1.aes_start_read = 1'b1;
        tick();
        chk1 ("last_en_c1",   if1.bram_en, 1'b1);
        chk32("last_addr_c1", if1.bram_addr, 32'h0000_0FFC);
        tick(); tick();
        chk1 ("last_cmp_c3",  if1.bram_complete, 1'b1);
        chk1 ("last_err_c3",  if1.bram_err, 1'b0);
        if1.aes_start_read = 1'b0;
        tick(); tick();

        // RD_LAT=3 read at 0x0
        if3.aes_bram_addr = 32'h0;
        if3.aes_start_read = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk1("lat3_busy", if3.ctrl_busy, 1'b1);
            chk1("lat3_en",   if3.bram_en, (c == 1));
            chk1("lat3_cmp",  if3.bram_complete, (c == 5));
        end
        chk32("lat3_data", if3.aes_bram_read_data, 32'h1234_5678);
        if3.aes_start_read = 1'b0;
        tick(); tick();
        chk1 ("lat3_idle_busy", if3.ctrl_busy, 1'b0);

        // Reset during RD_WAIT
        if3.aes_start_read = 1'b1;
        tick(); tick();
        rst3 = 1'b1;
        if3.aes_start_read = 1'b0;
        tick();
        chk1 ("mrst_en",    if3.bram_en, 1'b0);
        chk32("mrst_we",    {28'h0, if3.bram_we}, 32'h0);
        chk1 ("mrst_cmp",   if3.bram_complete, 1'b0);
        chk1 ("mrst_err",   if3.bram_err, 1'b0);
        chk1 ("mrst_busy",  if3.ctrl_busy, 1'b0);
        chk32("mrst_addr",  if3.bram_addr, 32'h0);
        chk32("mrst_rdata", if3.aes_bram_read_data, 32'h0);
        rst3 = 1'b0;
        n_cmp = 0;
        repeat (5) begin
            tick();
            n_cmp += int'(if3.bram_complete);
        end
        chk32("mrst_no_cmp", n_cmp, 0);
        if3.aes_start_read = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk1("post_en",  if3.bram_en, (c == 1));
            chk1("post_cmp", if3.bram_complete, (c == 5));
        end
        chk32("post_data", if3.aes_bram_read_data, 32'h1234_5678);
        if3.aes_start_read = 1'b0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
